// File: rtl/regs_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package regs_arb_pkg;

  // Arbiter control states: hold idle until the register file is ready, then grant.
  typedef enum logic {
    ST_WAIT_RDY = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  // Ceiling log2, used to size round-robin pointers and grant indices.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins,
// wrapping to the lowest set request otherwise.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic             w_hi_hit;
  logic             w_lo_hit;
  logic [PTR_W-1:0] w_hi_idx;
  logic [PTR_W-1:0] w_lo_idx;

  // Lowest request at/after ptr and lowest request overall (descending scan keeps the lowest).
  always_comb begin
    w_hi_hit = 1'b0;
    w_lo_hit = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_hit = 1'b1;
        w_lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= ptr) begin
          w_hi_hit = 1'b1;
          w_hi_idx = PTR_W'(i);
        end
      end
    end
  end

  // Pick the wrapped winner and expand it to a one-hot grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (en && w_lo_hit) begin
      gnt_idx = w_hi_hit ? w_hi_idx : w_lo_idx;
      gnt     = N'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/regs_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// The write port is driven from registers; idle cycles present an out-of-range address
// so the register file never commits spurious writes.
module regs_write_arbiter
  import regs_arb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned REGS_NUM  = 16,
  parameter int unsigned NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         regs_ready,
  output logic [BUS_WIDTH-1:0]         regs_addr_write,
  output logic [BUS_WIDTH-1:0]         regs_data_write,
  output logic [NUM_REQ-1:0]           oor_err,
  output logic                         busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam logic [BUS_WIDTH-1:0] IDLE_ADDR = {BUS_WIDTH{1'b1}};
  localparam logic [BUS_WIDTH-1:0] RANGE_END = BUS_WIDTH'(REGS_NUM);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 w_arb_en;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic                 w_grant;
  logic [BUS_WIDTH-1:0] w_sel_addr;
  logic [BUS_WIDTH-1:0] w_sel_data;
  logic                 w_in_range;
  logic [BUS_WIDTH-1:0] r_addr_write;
  logic [BUS_WIDTH-1:0] r_data_write;
  logic [NUM_REQ-1:0]   r_oor_err;
  logic                 r_busy;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAIT_RDY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; arbitration is enabled only while running with the register file ready.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      ST_WAIT_RDY: begin
        if (regs_ready) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!regs_ready) begin
          w_state_nxt = ST_WAIT_RDY;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_RDY;
      end
    endcase
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_grant   = |w_gnt;
  assign req_ready = w_gnt;

  // Mux the granted requester's address and data.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr[i*BUS_WIDTH +: BUS_WIDTH];
        w_sel_data = req_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Full-width compare so set upper bits can never alias onto a valid register.
  assign w_in_range = (w_sel_addr < RANGE_END);

  // Round-robin pointer: start next search just past the last winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      if (w_gnt_idx == PTR_W'(NUM_REQ - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_gnt_idx + PTR_W'(1);
      end
    end
  end

  // Write-port register: granted in-range write, otherwise idle; out-of-range grants are dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_write <= IDLE_ADDR;
      r_data_write <= '0;
      r_oor_err    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_addr_write <= IDLE_ADDR;
      r_data_write <= '0;
      r_oor_err    <= '0;
      r_busy       <= w_grant;
      if (w_grant) begin
        if (w_in_range) begin
          r_addr_write <= w_sel_addr;
          r_data_write <= w_sel_data;
        end else begin
          r_oor_err <= w_gnt;
        end
      end
    end
  end

  assign regs_addr_write = r_addr_write;
  assign regs_data_write = r_data_write;
  assign oor_err         = r_oor_err;
  assign busy            = r_busy;

endmodule

// File: tb/tb_regs_write_arbiter.sv
// Directed bench for regs_write_arbiter with a small register-file model on the write port.
module tb_regs_write_arbiter;

  localparam int unsigned BW = 32;
  localparam int unsigned NR = 4;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*BW-1:0] req_addr;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            regs_ready;
  logic [BW-1:0]   regs_addr_write;
  logic [BW-1:0]   regs_data_write;
  logic [NR-1:0]   oor_err;
  logic            busy;

  logic [31:0] a [4];
  logic [31:0] d [4];
  logic [31:0] tb_regs [16];

  int n_vec;
  int n_err;

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  regs_write_arbiter #(
    .BUS_WIDTH (32),
    .REGS_NUM  (16),
    .NUM_REQ   (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .regs_ready      (regs_ready),
    .regs_addr_write (regs_addr_write),
    .regs_data_write (regs_data_write),
    .oor_err         (oor_err),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: commits whenever the write address is in range.
  always @(posedge clk) begin
    if (regs_addr_write < 32'd16) tb_regs[regs_addr_write[3:0]] <= regs_data_write;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; regs_ready = 1'b0; req_valid = '0;
    for (int i = 0; i < 4; i++) begin a[i] = '0; d[i] = '0; end
    @(negedge clk);
    req_valid = 4'b0001; a[0] = 32'd1; d[0] = 32'h0000_0101;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    n_vec++; if (regs_addr_write !== IDLE) begin n_err++; $display("FAIL rst_addr got %h exp %h", regs_addr_write, IDLE); end
    n_vec++; if (regs_data_write !== 32'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", regs_data_write); end
    n_vec++; if (oor_err !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL rst_flags got oor=%b busy=%b exp 0000/0", oor_err, busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (req_ready !== 4'b0000 || regs_addr_write !== IDLE) begin
        n_err++; $display("FAIL wait_rdy cyc %0d got ready=%b addr=%h exp 0000/%h", c, req_ready, regs_addr_write, IDLE);
      end
      @(negedge clk);
    end
    regs_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rdy_same_cycle got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL first_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if (regs_addr_write !== 32'd1 || regs_data_write !== 32'h101 || busy !== 1'b1) begin
      n_err++; $display("FAIL first_write got addr=%h data=%h busy=%b exp 1/101/1", regs_addr_write, regs_data_write, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin a[i] = 32'(i + 1); d[i] = 32'hD000_0000 + 32'(i); end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_vec++; if (req_ready !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
      @(negedge clk);
      n_vec++; if (regs_addr_write !== 32'((k % 4) + 1) || regs_data_write !== 32'hD000_0000 + 32'(k % 4)) begin
        n_err++; $display("FAIL rr_write k=%0d got addr=%h data=%h exp %h/%h", k, regs_addr_write, regs_data_write, (k % 4) + 1, 32'hD000_0000 + 32'(k % 4));
      end
    end
    req_valid = '0;
    @(negedge clk);
    for (int r = 1; r <= 4; r++) begin
      n_vec++; if (tb_regs[r] !== 32'hD000_0000 + 32'(r - 1)) begin n_err++; $display("FAIL rr_regs r%0d got %h exp %h", r, tb_regs[r], 32'hD000_0000 + 32'(r - 1)); end
    end
  endtask

  task automatic test_same_target();
    // One grant to requester 0 moves the pointer to 1.
    a[0] = 32'd7; d[0] = 32'h77; req_valid = 4'b0001;
    @(negedge clk);
    a[1] = 32'd5; d[1] = 32'hAAAA; a[2] = 32'd5; d[2] = 32'hBBBB; req_valid = 4'b0110;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL same_g1 got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL same_g2 got %b exp 0100", req_ready); end
    n_vec++; if (regs_addr_write !== 32'd5 || regs_data_write !== 32'hAAAA) begin n_err++; $display("FAIL same_w1 got %h/%h exp 5/AAAA", regs_addr_write, regs_data_write); end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if (regs_addr_write !== 32'd5 || regs_data_write !== 32'hBBBB) begin n_err++; $display("FAIL same_w2 got %h/%h exp 5/BBBB", regs_addr_write, regs_data_write); end
    @(negedge clk);
    n_vec++; if (tb_regs[5] !== 32'hBBBB || tb_regs[7] !== 32'h77) begin n_err++; $display("FAIL same_regs got r5=%h r7=%h exp BBBB/77", tb_regs[5], tb_regs[7]); end
  endtask

  task automatic test_oor();
    // Pointer is 3 here; requester 0 wins after wrap.
    a[0] = 32'd16; d[0] = 32'h1616; req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL oor_g16 got %b exp 0001", req_ready); end
    @(negedge clk);
    n_vec++; if (oor_err !== 4'b0001 || regs_addr_write !== IDLE || regs_data_write !== 32'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL oor_16 got oor=%b addr=%h data=%h busy=%b exp 0001/%h/0/1", oor_err, regs_addr_write, regs_data_write, busy, IDLE);
    end
    a[0] = 32'h8000_0003; d[0] = 32'h3333;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL oor_ghi got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if (oor_err !== 4'b0001 || regs_addr_write !== IDLE) begin n_err++; $display("FAIL oor_hi got oor=%b addr=%h exp 0001/%h", oor_err, regs_addr_write, IDLE); end
    @(negedge clk);
    n_vec++; if (oor_err !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL oor_pulse got oor=%b busy=%b exp 0000/0", oor_err, busy); end
    n_vec++; if (tb_regs[3] !== 32'hD000_0002) begin n_err++; $display("FAIL oor_regs got r3=%h exp D0000002", tb_regs[3]); end
  endtask

  task automatic test_reset_mid();
    // Pointer is 1; preload r9 through requester 2.
    a[2] = 32'd9; d[2] = 32'h11; req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    d[2] = 32'h99; req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_grant got %b exp 0100", req_ready); end
    @(negedge clk);
    n_vec++; if (regs_addr_write !== 32'd9 || regs_data_write !== 32'h99) begin n_err++; $display("FAIL mid_write got %h/%h exp 9/99", regs_addr_write, regs_data_write); end
    reset = 1'b1; req_valid = '0;
    #1;
    n_vec++; if (regs_addr_write !== IDLE || regs_data_write !== 32'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_clear got addr=%h data=%h busy=%b exp %h/0/0", regs_addr_write, regs_data_write, busy, IDLE);
    end
    @(negedge clk);
    n_vec++; if (tb_regs[9] !== 32'h11) begin n_err++; $display("FAIL mid_regs got r9=%h exp 11", tb_regs[9]); end
    reset = 1'b0;
    @(negedge clk);
    a[0] = 32'd12; d[0] = 32'hC12;
    req_valid = 4'b1111;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_ready_drop();
    // Pointer is 1, FSM running.
    a[3] = 32'd10; d[3] = 32'hCC; req_valid = 4'b1000; regs_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL drop_nogrant got %b exp 0000", req_ready); end
    @(negedge clk);
    n_vec++; if (regs_addr_write !== IDLE || busy !== 1'b0) begin n_err++; $display("FAIL drop_idle got addr=%h busy=%b exp %h/0", regs_addr_write, busy, IDLE); end
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL drop_wait got %b exp 0000", req_ready); end
    @(negedge clk);
    regs_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL drop_ret got %b exp 0000", req_ready); end
    @(negedge clk); #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL drop_resume got %b exp 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if (regs_addr_write !== 32'd10 || regs_data_write !== 32'hCC) begin n_err++; $display("FAIL drop_write got %h/%h exp A/CC", regs_addr_write, regs_data_write); end
    @(negedge clk);
    n_vec++; if (tb_regs[10] !== 32'hCC || tb_regs[12] !== 32'hC12) begin n_err++; $display("FAIL drop_regs got r10=%h r12=%h exp CC/C12", tb_regs[10], tb_regs[12]); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_same_target();
    test_oor();
    test_reset_mid();
    test_ready_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
